status_ctrl: RTL and testbench

Controller for the NZCV status register. Arbitrates flag writes from the EXE-stage ALU (S-bit instructions) and explicit MSR-style writes. Sequences exception entry/return by saving and restoring flags on a small hardware stack. Evaluates ARM condition codes for the ID stage and drives the status register's load/status_in pins.

---
 rtl/status_ctrl_if.sv | 38 +++
 rtl/status_ctrl.sv | 160 ++++++++++++++++
 tb/tb_status_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/status_ctrl_if.sv
// Flag-control bundle between the pipeline and status_ctrl.
// slave = controller view, master = pipeline/driver view.
interface status_ctrl_if #(
   parameter int unsigned LEN = 4,
   parameter int unsigned DW  = 2
);
   logic           alu_s;
   logic [LEN-1:0] alu_status_in;
   logic           exe_flush;
   logic           msr_valid;
   logic [LEN-1:0] msr_data;
   logic           msr_ready;
   logic           exc_enter;
   logic           exc_return;
   logic [LEN-1:0] sr_status;
   logic           sr_load;
   logic [LEN-1:0] sr_in;
   logic [3:0]     cond;
   logic           cond_pass;
   logic           busy;
   logic [DW-1:0]  stack_depth;
   logic [LEN-1:0] saved_top;
   logic           exc_err;

   modport slave (
      input  alu_s, alu_status_in, exe_flush, msr_valid, msr_data,
             exc_enter, exc_return, sr_status, cond,
      output msr_ready, sr_load, sr_in, cond_pass, busy,
             stack_depth, saved_top, exc_err
   );

   modport master (
      output alu_s, alu_status_in, exe_flush, msr_valid, msr_data,
             exc_enter, exc_return, sr_status, cond,
      input  msr_ready, sr_load, sr_in, cond_pass, busy,
             stack_depth, saved_top, exc_err
   );
endinterface

// File: rtl/status_ctrl.sv
// NZCV status controller: ALU/MSR flag-write arbitration, exception save/restore stack,
// condition evaluation. Define STATUS_FWD_EN to forward a pending same-cycle load into cond_pass.
module status_ctrl #(
   parameter int unsigned LEN        = 4,
   parameter int unsigned SAVE_DEPTH = 2,
   parameter int unsigned DW         = 2
) (
   input  logic         clk,
   input  logic         rst,
   status_ctrl_if.slave bus
);
   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_SAVE    = 2'd1;
   localparam logic [1:0] ST_RESTORE = 2'd2;

   localparam logic [DW-1:0] FULL = DW'(SAVE_DEPTH);

   logic [1:0]     state_q, state_d;
   logic [DW-1:0]  depth_q, depth_d;
   logic [LEN-1:0] slot_q [SAVE_DEPTH];
   logic [LEN-1:0] slot_d [SAVE_DEPTH];
   logic [LEN-1:0] restore_q, restore_d;
   logic           err_q, err_d;

   logic           in_run;
   logic           ret_win, ent_win, msr_win, alu_win;
   logic           load_raw;
   logic [LEN-1:0] sr_in_raw;
   logic [LEN-1:0] top;
   logic [LEN-1:0] flags;

   function automatic logic cond_eval(input logic [3:0] c, input logic [LEN-1:0] f);
      logic n, z, cf, v;
      n  = f[3];
      z  = f[2];
      cf = f[1];
      v  = f[0];
      case (c)
         4'b0000: cond_eval = z;
         4'b0001: cond_eval = !z;
         4'b0010: cond_eval = cf;
         4'b0011: cond_eval = !cf;
         4'b0100: cond_eval = n;
         4'b0101: cond_eval = !n;
         4'b0110: cond_eval = v;
         4'b0111: cond_eval = !v;
         4'b1000: cond_eval = cf & !z;
         4'b1001: cond_eval = !cf | z;
         4'b1010: cond_eval = (n == v);
         4'b1011: cond_eval = (n != v);
         4'b1100: cond_eval = !z & (n == v);
         4'b1101: cond_eval = z | (n != v);
         4'b1110: cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

   // Fixed priority in RUN: return > enter > MSR > ALU.
   assign in_run  = (state_q == ST_RUN);
   assign ret_win = in_run & bus.exc_return;
   assign ent_win = in_run & ~bus.exc_return & bus.exc_enter;
   assign msr_win = in_run & ~bus.exc_return & ~bus.exc_enter & bus.msr_valid;
   assign alu_win = in_run & ~bus.exc_return & ~bus.exc_enter & ~bus.msr_valid
                  & bus.alu_s & ~bus.exe_flush;

   always_comb begin
      top = '0;
      for (int unsigned i = 0; i < SAVE_DEPTH; i++) begin
         if (depth_q == DW'(i + 1)) top = slot_q[i];
      end
   end

   always_comb begin
      load_raw  = 1'b0;
      sr_in_raw = '0;
      case (state_q)
         ST_SAVE: begin
            load_raw  = 1'b1;
            sr_in_raw = '0;
         end
         ST_RESTORE: begin
            load_raw  = 1'b1;
            sr_in_raw = restore_q;
         end
         default: begin
            if (msr_win) begin
               load_raw  = 1'b1;
               sr_in_raw = bus.msr_data;
            end else if (alu_win) begin
               load_raw  = 1'b1;
               sr_in_raw = bus.alu_status_in;
            end
         end
      endcase
   end

`ifdef STATUS_FWD_EN
   assign flags = (in_run && load_raw) ? sr_in_raw : bus.sr_status;
`else
   assign flags = bus.sr_status;
`endif

   // Strobes are gated by the live reset level so nothing fires while rst is held low.
   assign bus.sr_load     = rst & load_raw;
   assign bus.sr_in       = sr_in_raw;
   assign bus.msr_ready   = rst & msr_win;
   assign bus.busy        = rst & ~in_run;
   assign bus.cond_pass   = rst & in_run & cond_eval(bus.cond, flags);
   assign bus.stack_depth = depth_q;
   assign bus.saved_top   = top;
   assign bus.exc_err     = err_q;

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      restore_d = restore_q;
      err_d     = err_q;
      slot_d    = slot_q;
      case (state_q)
         ST_RUN: begin
            if (ret_win) begin
               if (depth_q != '0) begin
                  restore_d = top;
                  depth_d   = depth_q - DW'(1);
                  state_d   = ST_RESTORE;
               end else begin
                  err_d = 1'b1;
               end
            end else if (ent_win) begin
               state_d = ST_SAVE;
               if (depth_q < FULL) begin
                  for (int unsigned i = 0; i < SAVE_DEPTH; i++) begin
                     if (depth_q == DW'(i)) slot_d[i] = bus.sr_status;
                  end
                  depth_d = depth_q + DW'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         depth_q   <= '0;
         restore_q <= '0;
         err_q     <= 1'b0;
         for (int unsigned i = 0; i < SAVE_DEPTH; i++) slot_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         depth_q   <= depth_d;
         restore_q <= restore_d;
         err_q     <= err_d;
         for (int unsigned i = 0; i < SAVE_DEPTH; i++) slot_q[i] <= slot_d[i];
      end
   end
endmodule

// File: tb/tb_status_ctrl.sv
// Scoreboard bench for status_ctrl: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares every output.
module tb_status_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

`ifdef STATUS_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   status_ctrl_if #(.LEN(4), .DW(2)) bus ();

   status_ctrl #(.LEN(4), .SAVE_DEPTH(2), .DW(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string      nm;
      logic       ld;
      logic [3:0] in;
      logic       mr;
      logic       bsy;
      logic       cp;
      logic [1:0] dep;
      logic [3:0] top;
      logic       err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.nm, "sr_load",     {3'b0, bus.sr_load},     {3'b0, e.ld});
            if (e.ld) chk(e.nm, "sr_in", bus.sr_in, e.in);
            chk(e.nm, "msr_ready",   {3'b0, bus.msr_ready},   {3'b0, e.mr});
            chk(e.nm, "busy",        {3'b0, bus.busy},        {3'b0, e.bsy});
            chk(e.nm, "cond_pass",   {3'b0, bus.cond_pass},   {3'b0, e.cp});
            chk(e.nm, "stack_depth", {2'b0, bus.stack_depth}, {2'b0, e.dep});
            chk(e.nm, "saved_top",   bus.saved_top,           e.top);
            chk(e.nm, "exc_err",     {3'b0, bus.exc_err},     {3'b0, e.err});
         end
      end
   end

   task automatic step(
      input string nm, input logic r,
      input logic as, input logic [3:0] ai, input logic fl,
      input logic mv, input logic [3:0] md,
      input logic ee, input logic er,
      input logic [3:0] srs, input logic [3:0] c,
      input logic eld, input logic [3:0] ein, input logic emr, input logic ebsy,
      input logic ecp, input logic [1:0] edep, input logic [3:0] etop, input logic eerr);
      exp_t x;
      @(posedge clk);
      #1;
      rst               = r;
      bus.alu_s         = as;
      bus.alu_status_in = ai;
      bus.exe_flush     = fl;
      bus.msr_valid     = mv;
      bus.msr_data      = md;
      bus.exc_enter     = ee;
      bus.exc_return    = er;
      bus.sr_status     = srs;
      bus.cond          = c;
      x.nm  = nm;  x.ld  = eld;  x.in  = ein;  x.mr  = emr;
      x.bsy = ebsy; x.cp = ecp;  x.dep = edep; x.top = etop; x.err = eerr;
      sb.push_back(x);
   endtask

   initial begin
      rst = 1'b1;
      bus.alu_s = 1'b0; bus.alu_status_in = '0; bus.exe_flush = 1'b0;
      bus.msr_valid = 1'b0; bus.msr_data = '0; bus.exc_enter = 1'b0;
      bus.exc_return = 1'b0; bus.sr_status = '0; bus.cond = '0;
      #1 rst = 1'b0;
      //     name          rst as ai      fl mv md      ee er srs     cond     ld in      mr bsy cp   dep    top     err
      step("reset",        0, 0, 4'h0, 0, 1, 4'b1010, 0, 0, 4'b0000, 4'b1110, 0, 4'h0,   0, 0, 0,   2'd0, 4'h0,   0);
      step("eq_z",         1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0100, 4'b0000, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("ne_z",         1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0100, 4'b0001, 0, 4'h0,   0, 0, 0,   2'd0, 4'h0,   0);
      step("nv",           1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0100, 4'b1111, 0, 4'h0,   0, 0, 0,   2'd0, 4'h0,   0);
      step("al",           1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0100, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("ge",           1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b1001, 4'b1010, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("gt",           1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b1001, 4'b1100, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("hi_no",        1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b1001, 4'b1000, 0, 4'h0,   0, 0, 0,   2'd0, 4'h0,   0);
      step("lt",           1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b1001, 4'b1011, 0, 4'h0,   0, 0, 0,   2'd0, 4'h0,   0);
      step("hi_yes",       1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0010, 4'b1000, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("le",           1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0010, 4'b1101, 0, 4'h0,   0, 0, 0,   2'd0, 4'h0,   0);
      step("msr_over_alu", 1, 1, 4'b0001, 0, 1, 4'b1010, 0, 0, 4'b0100, 4'b0000, 1, 4'b1010, 1, 0, !FWD, 2'd0, 4'h0, 0);
      step("alu_flush",    1, 1, 4'b0001, 1, 0, 4'h0,    0, 0, 4'b0100, 4'b0000, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("alu_load",     1, 1, 4'b0011, 0, 0, 4'h0,    0, 0, 4'b0100, 4'b0000, 1, 4'b0011, 0, 0, !FWD, 2'd0, 4'h0, 0);
      step("alu_fwd",      1, 1, 4'b0100, 0, 0, 4'h0,    0, 0, 4'b0000, 4'b0000, 1, 4'b0100, 0, 0, FWD, 2'd0, 4'h0,  0);
      step("enter1",       1, 0, 4'h0, 0, 1, 4'h5,    1, 0, 4'b0110, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("save1",        1, 0, 4'h0, 0, 1, 4'h5,    0, 0, 4'b0110, 4'b1110, 1, 4'h0,   0, 1, 0,   2'd1, 4'b0110, 0);
      step("ret_over_ent", 1, 0, 4'h0, 0, 0, 4'h0,    1, 1, 4'b0000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd1, 4'b0110, 0);
      step("restore1",     1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0000, 4'b1110, 1, 4'b0110, 0, 1, 0,  2'd0, 4'h0,   0);
      step("idle_z",       1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0110, 4'b0000, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("nest_ent1",    1, 0, 4'h0, 0, 0, 4'h0,    1, 0, 4'b1000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("nest_save1",   1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b1000, 4'b1110, 1, 4'h0,   0, 1, 0,   2'd1, 4'b1000, 0);
      step("nest_ent2",    1, 0, 4'h0, 0, 0, 4'h0,    1, 0, 4'b0001, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd1, 4'b1000, 0);
      step("nest_save2",   1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0001, 4'b1110, 1, 4'h0,   0, 1, 0,   2'd2, 4'b0001, 0);
      step("nest_ent3",    1, 0, 4'h0, 0, 0, 4'h0,    1, 0, 4'b0000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd2, 4'b0001, 0);
      step("full_save",    1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0000, 4'b1110, 1, 4'h0,   0, 1, 0,   2'd2, 4'b0001, 1);
      step("nest_ret2",    1, 0, 4'h0, 0, 0, 4'h0,    0, 1, 4'b0000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd2, 4'b0001, 1);
      step("nest_rst2",    1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0000, 4'b1110, 1, 4'b0001, 0, 1, 0,  2'd1, 4'b1000, 1);
      step("nest_ret1",    1, 0, 4'h0, 0, 0, 4'h0,    0, 1, 4'b0001, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd1, 4'b1000, 1);
      step("nest_rst1",    1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0001, 4'b1110, 1, 4'b1000, 0, 1, 0,  2'd0, 4'h0,   1);
      step("ret_empty",    1, 0, 4'h0, 0, 1, 4'h3,    0, 1, 4'b1000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   1);
      step("after_empty",  1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b1000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   1);
      step("pre_rst_ent",  1, 0, 4'h0, 0, 0, 4'h0,    1, 0, 4'b0101, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   1);
      step("rst_mid_save", 0, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0101, 4'b1110, 0, 4'h0,   0, 0, 0,   2'd0, 4'h0,   0);
      step("post_rst",     1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("ret_empty2",   1, 0, 4'h0, 0, 0, 4'h0,    0, 1, 4'b0000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   0);
      step("err_sticky",   1, 0, 4'h0, 0, 0, 4'h0,    0, 0, 4'b0000, 4'b1110, 0, 4'h0,   0, 0, 1,   2'd0, 4'h0,   1);
      for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clk);
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
